// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register file's single write port between the ALU writeback path
// and the memory-load writeback path. Each source has a small FIFO of
// (dest, value) pairs. A round-robin scheduler pops at most one head per cycle
// onto registered write-port outputs. A combinational scoreboard flags decode
// source registers that still have a queued or in-flight result.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   alu_valid/ready/dest/val     ALU writeback push handshake
//   mem_valid/ready/dest/val     load writeback push handshake
//   write_enable, dest, destVal  registered register-file write port
//   chk_addr1, chk_addr2         decode-stage source register indices
//   hazard                       a pending result targets chk_addr1/chk_addr2
//   busy                         at least one queue holds an entry
module wb_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_dest,
   input  logic [DATA_W-1:0] alu_val,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_dest,
   input  logic [DATA_W-1:0] mem_val,
   output logic              write_enable,
   output logic [ADDR_W-1:0] dest,
   output logic [DATA_W-1:0] destVal,
   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              hazard,
   output logic              busy
);
   localparam int PW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int NSRC = 2;   // source 0 = ALU, source 1 = load path

   logic [NSRC-1:0]   in_valid;
   logic [NSRC-1:0]   in_ready;
   logic [NSRC-1:0]   push;
   logic [NSRC-1:0]   pop;
   logic [NSRC-1:0]   nonempty;
   logic [NSRC-1:0]   src_hazard;
   logic [ADDR_W-1:0] in_dest   [NSRC];
   logic [DATA_W-1:0] in_val    [NSRC];
   logic [ADDR_W-1:0] head_dest [NSRC];
   logic [DATA_W-1:0] head_val  [NSRC];

   // 1 = load path was granted last; reset value makes the ALU win the first tie.
   logic              last_mem_q, last_mem_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
   logic [DATA_W-1:0] wr_val_q, wr_val_d;

   assign in_valid   = {mem_valid, alu_valid};
   assign in_dest[0] = alu_dest;
   assign in_dest[1] = mem_dest;
   assign in_val[0]  = alu_val;
   assign in_val[1]  = mem_val;
   assign alu_ready  = in_ready[0];
   assign mem_ready  = in_ready[1];

   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_queue
         logic [ADDR_W-1:0] dest_q [DEPTH];
         logic [DATA_W-1:0] val_q  [DEPTH];
         logic [DEPTH-1:0]  vld_q, vld_d;
         logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
         logic [CW-1:0]     count_q;
         logic              hit;

         // Ready comes only from the registered count, so a full queue
         // refuses a push even in a cycle where it pops.
         assign in_ready[gi]  = reset_n && (count_q < CW'(DEPTH));
         assign push[gi]      = in_valid[gi] && in_ready[gi];
         assign nonempty[gi]  = (count_q != '0);
         assign head_dest[gi] = dest_q[rd_ptr_q];
         assign head_val[gi]  = val_q[rd_ptr_q];

         // Per-slot valid bits drive the scoreboard; a push never lands on the
         // slot being popped because a full queue does not accept.
         always_comb begin
            vld_d = vld_q;
            if (pop[gi])  vld_d[rd_ptr_q] = 1'b0;
            if (push[gi]) vld_d[wr_ptr_q] = 1'b1;
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               vld_q    <= '0;
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               count_q  <= '0;
            end else begin
               vld_q   <= vld_d;
               count_q <= count_q + CW'(push[gi]) - CW'(pop[gi]);
               if (push[gi]) wr_ptr_q <= wr_ptr_q + PW'(1);
               if (pop[gi])  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
         end

         // Payload storage needs no reset: slot validity is tracked separately.
         always_ff @(posedge clk) begin
            if (push[gi]) begin
               dest_q[wr_ptr_q] <= in_dest[gi];
               val_q[wr_ptr_q]  <= in_val[gi];
            end
         end

         always_comb begin
            hit = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
               if (vld_q[i] && (dest_q[i] != '0) &&
                   ((dest_q[i] == chk_addr1) || (dest_q[i] == chk_addr2)))
                  hit = 1'b1;
            end
         end
         assign src_hazard[gi] = hit;
      end
   endgenerate

   // Round robin: a lone non-empty queue always pops; on a tie the source
   // that was not granted last goes first.
   assign pop[0] = nonempty[0] && (!nonempty[1] || last_mem_q);
   assign pop[1] = nonempty[1] && !pop[0];

   always_comb begin
      last_mem_d = last_mem_q;
      wr_en_d    = 1'b0;
      wr_dest_d  = wr_dest_q;
      wr_val_d   = wr_val_q;
      if (pop[0]) begin
         last_mem_d = 1'b0;
         wr_dest_d  = head_dest[0];
         wr_val_d   = head_val[0];
         wr_en_d    = (head_dest[0] != '0);   // r0 writes are dropped silently
      end else if (pop[1]) begin
         last_mem_d = 1'b1;
         wr_dest_d  = head_dest[1];
         wr_val_d   = head_val[1];
         wr_en_d    = (head_dest[1] != '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_mem_q <= 1'b1;
         wr_en_q    <= 1'b0;
         wr_dest_q  <= '0;
         wr_val_q   <= '0;
      end else begin
         last_mem_q <= last_mem_d;
         wr_en_q    <= wr_en_d;
         wr_dest_q  <= wr_dest_d;
         wr_val_q   <= wr_val_d;
      end
   end

   assign write_enable = wr_en_q;
   assign dest         = wr_dest_q;
   assign destVal      = wr_val_q;
   assign busy         = |nonempty;
   // The output stage stays visible until its write pulse ends; wr_en_q
   // already implies a non-zero destination.
   assign hazard = (|src_hazard) ||
                   (wr_en_q && ((wr_dest_q == chk_addr1) || (wr_dest_q == chk_addr2)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              alu_valid = 1'b0, mem_valid = 1'b0;
   logic              alu_ready, mem_ready;
   logic [ADDR_W-1:0] alu_dest = '0, mem_dest = '0;
   logic [DATA_W-1:0] alu_val = '0, mem_val = '0;
   logic              write_enable;
   logic [ADDR_W-1:0] dest;
   logic [DATA_W-1:0] destVal;
   logic [ADDR_W-1:0] chk_addr1 = '0, chk_addr2 = '0;
   logic              hazard, busy;

   int checks = 0;
   int errors = 0;

   wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_val(alu_val),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_val(mem_val),
      .write_enable(write_enable), .dest(dest), .destVal(destVal),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard(hazard), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] d;
      logic [DATA_W-1:0] v;
   } ent_t;

   // Reference model: per-source queues, last winner, registered write port.
   ent_t              mq_alu[$];
   ent_t              mq_mem[$];
   bit                m_last_mem;
   bit                m_we;
   logic [ADDR_W-1:0] m_dest;
   logic [DATA_W-1:0] m_val;

   // Observed register-file side: writes log and register contents.
   ent_t              wlog[$];
   logic [DATA_W-1:0] rf [32];

   always @(negedge clk) begin
      if (write_enable) begin
         ent_t e;
         e.d = dest;
         e.v = destVal;
         wlog.push_back(e);
         rf[dest] = destVal;
         $display("write r%0d = %h", dest, destVal);
      end
   end

   task automatic model_reset();
      mq_alu.delete();
      mq_mem.delete();
      m_last_mem = 1'b1;
      m_we       = 1'b0;
      m_dest     = '0;
      m_val      = '0;
   endtask

   function automatic bit m_hazard(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
      bit h = 1'b0;
      foreach (mq_alu[i])
         if (mq_alu[i].d != 0 && (mq_alu[i].d == a1 || mq_alu[i].d == a2)) h = 1'b1;
      foreach (mq_mem[i])
         if (mq_mem[i].d != 0 && (mq_mem[i].d == a1 || mq_mem[i].d == a2)) h = 1'b1;
      if (m_we && (m_dest == a1 || m_dest == a2)) h = 1'b1;
      return h;
   endfunction

   // One clock: advance the model with the current inputs, end at the falling edge.
   task automatic tick();
      bit   acc_a, acc_m, pa, pm;
      ent_t e;
      acc_a = alu_valid && (mq_alu.size() < DEPTH);
      acc_m = mem_valid && (mq_mem.size() < DEPTH);
      pa    = (mq_alu.size() != 0) && ((mq_mem.size() == 0) || m_last_mem);
      pm    = (mq_mem.size() != 0) && !pa;
      @(posedge clk);
      if (pa || pm) begin
         e = pa ? mq_alu.pop_front() : mq_mem.pop_front();
         m_last_mem = pm;
         m_we   = (e.d != 0);
         m_dest = e.d;
         m_val  = e.v;
      end else begin
         m_we = 1'b0;
      end
      if (acc_a) begin e.d = alu_dest; e.v = alu_val; mq_alu.push_back(e); end
      if (acc_m) begin e.d = mem_dest; e.v = mem_val; mq_mem.push_back(e); end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", write_enable); end
      checks++; if (dest !== '0) begin errors++; $display("FAIL reset_dest got %0d want 0", dest); end
      checks++; if (destVal !== '0) begin errors++; $display("FAIL reset_val got %h want 0", destVal); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", hazard); end
      checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready got %b%b want 00", alu_ready, mem_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      #1;
      checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
         errors++; $display("FAIL release_ready got %b%b want 11", alu_ready, mem_ready);
      end
   endtask

   task automatic test_tie_alternate();
      int na = 0, nm = 0, ia = 0, im = 0;
      bit a_low = 1'b0, m_low = 1'b0;
      wlog.delete();
      for (int i = 0; i < 6; i++) begin
         alu_valid = 1'b1; alu_dest = 5; alu_val = 32'h11 + na;
         mem_valid = 1'b1; mem_dest = 6; mem_val = 32'h22 + nm;
         #1;
         if (!alu_ready) a_low = 1'b1; else na++;
         if (!mem_ready) m_low = 1'b1; else nm++;
         tick();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      repeat (2 * DEPTH + 2) tick();
      #1;
      checks++; if (a_low !== 1'b1) begin errors++; $display("FAIL tie_alu_ready_drop got %b want 1", a_low); end
      checks++; if (m_low !== 1'b1) begin errors++; $display("FAIL tie_mem_ready_drop got %b want 1", m_low); end
      checks++; if (wlog.size() != na + nm) begin
         errors++; $display("FAIL tie_write_count got %0d want %0d", wlog.size(), na + nm);
      end
      for (int i = 0; i < wlog.size(); i++) begin
         if (i < 6) begin
            checks++; if (wlog[i].d !== ((i % 2 == 0) ? 5'd5 : 5'd6)) begin
               errors++; $display("FAIL tie_alternate[%0d] got r%0d want r%0d", i, wlog[i].d, (i % 2 == 0) ? 5 : 6);
            end
         end
         if (wlog[i].d == 5) begin
            checks++; if (wlog[i].v !== 32'h11 + ia) begin
               errors++; $display("FAIL tie_alu_order got %h want %h", wlog[i].v, 32'h11 + ia);
            end
            ia++;
         end else begin
            checks++; if (wlog[i].v !== 32'h22 + im) begin
               errors++; $display("FAIL tie_mem_order got %h want %h", wlog[i].v, 32'h22 + im);
            end
            im++;
         end
      end
   endtask

   task automatic test_single_push();
      alu_valid = 1'b1; alu_dest = 3; alu_val = 32'hDEADBEEF;
      tick();
      alu_valid = 1'b0;
      #1;
      checks++; if (write_enable !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL single_accept we/busy got %b/%b want 0/1", write_enable, busy);
      end
      tick();
      #1;
      checks++; if (write_enable !== 1'b1 || dest !== 5'd3 || destVal !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_write got %b r%0d %h want 1 r3 deadbeef", write_enable, dest, destVal);
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear got %b want 0", busy); end
      tick();
      #1;
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL single_pulse_len got %b want 0", write_enable); end
   endtask

   task automatic test_r0();
      chk_addr1 = 0; chk_addr2 = 0;
      alu_valid = 1'b1; alu_dest = 0; alu_val = 32'hFFFFFFFF;
      tick();
      alu_valid = 1'b0;
      #1;
      checks++; if (hazard !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL r0_queued hazard/busy got %b/%b want 0/1", hazard, busy);
      end
      tick();
      #1;
      checks++; if (write_enable !== 1'b0 || busy !== 1'b0 || hazard !== 1'b0) begin
         errors++; $display("FAIL r0_consumed we/busy/hazard got %b/%b/%b want 0/0/0", write_enable, busy, hazard);
      end
   endtask

   task automatic test_hazard(input logic [ADDR_W-1:0] c2, input bit expect_hit);
      bit saw = 1'b0;
      bit written = 1'b0;
      chk_addr1 = 20; chk_addr2 = c2;
      wlog.delete();
      for (int i = 0; i < 18; i++) begin
         alu_valid = (i < 12); alu_dest = 1; alu_val = $urandom;
         mem_valid = (i == 3); mem_dest = 9; mem_val = 32'h900D;
         #1;
         checks++; if (hazard !== m_hazard(chk_addr1, chk_addr2)) begin
            errors++; $display("FAIL hazard_c%0d[%0d] got %b want %b", c2, i, hazard, m_hazard(chk_addr1, chk_addr2));
         end
         if (hazard) saw = 1'b1;
         tick();
      end
      #1;
      foreach (wlog[i]) if (wlog[i].d == 9 && wlog[i].v == 32'h900D) written = 1'b1;
      checks++; if (saw !== expect_hit) begin
         errors++; $display("FAIL hazard_seen_c%0d got %b want %b", c2, saw, expect_hit);
      end
      checks++; if (written !== 1'b1 || hazard !== 1'b0) begin
         errors++; $display("FAIL hazard_drain_c%0d written/hazard got %b/%b want 1/0", c2, written, hazard);
      end
   endtask

   task automatic test_order();
      chk_addr1 = 0; chk_addr2 = 0;
      wlog.delete();
      for (int v = 1; v <= 3; v++) begin
         alu_valid = 1'b1; alu_dest = 7; alu_val = v;
         #1;
         checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL order_ready[%0d] got %b want 1", v, alu_ready); end
         tick();
      end
      alu_valid = 1'b0;
      repeat (4) tick();
      #1;
      checks++; if (wlog.size() != 3) begin errors++; $display("FAIL order_count got %0d want 3", wlog.size()); end
      for (int i = 0; i < wlog.size() && i < 3; i++) begin
         checks++; if (wlog[i].d !== 5'd7 || wlog[i].v !== 32'(i + 1)) begin
            errors++; $display("FAIL order[%0d] got r%0d %0d want r7 %0d", i, wlog[i].d, wlog[i].v, i + 1);
         end
      end
      checks++; if (rf[7] !== 32'd3) begin errors++; $display("FAIL order_final got %0d want 3", rf[7]); end
   endtask

   task automatic test_async_reset();
      chk_addr1 = 11; chk_addr2 = 12;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1; alu_dest = 11; alu_val = $urandom;
         mem_valid = 1'b1; mem_dest = 12; mem_val = $urandom;
         tick();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (write_enable !== 1'b0 || busy !== 1'b0 || hazard !== 1'b0) begin
         errors++; $display("FAIL async_reset we/busy/hazard got %b/%b/%b want 0/0/0", write_enable, busy, hazard);
      end
      checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         errors++; $display("FAIL async_reset_ready got %b%b want 00", alu_ready, mem_ready);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      alu_valid = 1'b1; alu_dest = 13; alu_val = 32'hA13;
      mem_valid = 1'b1; mem_dest = 14; mem_val = 32'hB14;
      tick();
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
      #1;
      checks++; if (write_enable !== 1'b1 || dest !== 5'd13 || destVal !== 32'hA13) begin
         errors++; $display("FAIL post_reset_tie got %b r%0d %h want 1 r13 a13", write_enable, dest, destVal);
      end
      tick();
      #1;
      checks++; if (write_enable !== 1'b1 || dest !== 5'd14 || destVal !== 32'hB14) begin
         errors++; $display("FAIL post_reset_second got %b r%0d %h want 1 r14 b14", write_enable, dest, destVal);
      end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         alu_valid = ($urandom_range(0, 3) != 0); alu_dest = $urandom_range(0, 7); alu_val = $urandom;
         mem_valid = ($urandom_range(0, 3) != 0); mem_dest = $urandom_range(0, 7); mem_val = $urandom;
         chk_addr1 = $urandom_range(0, 7); chk_addr2 = $urandom_range(0, 7);
         #1;
         checks++; if (alu_ready !== (mq_alu.size() < DEPTH)) begin
            errors++; $display("FAIL rnd_alu_ready[%0d] got %b want %b", c, alu_ready, mq_alu.size() < DEPTH);
         end
         checks++; if (mem_ready !== (mq_mem.size() < DEPTH)) begin
            errors++; $display("FAIL rnd_mem_ready[%0d] got %b want %b", c, mem_ready, mq_mem.size() < DEPTH);
         end
         checks++; if (busy !== (mq_alu.size() != 0 || mq_mem.size() != 0)) begin
            errors++; $display("FAIL rnd_busy[%0d] got %b want %b", c, busy, mq_alu.size() != 0 || mq_mem.size() != 0);
         end
         checks++; if (write_enable !== m_we || dest !== m_dest || destVal !== m_val) begin
            errors++; $display("FAIL rnd_write[%0d] got %b r%0d %h want %b r%0d %h", c, write_enable, dest, destVal, m_we, m_dest, m_val);
         end
         checks++; if (hazard !== m_hazard(chk_addr1, chk_addr2)) begin
            errors++; $display("FAIL rnd_hazard[%0d] got %b want %b", c, hazard, m_hazard(chk_addr1, chk_addr2));
         end
         tick();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_tie_alternate();
      test_single_push();
      test_r0();
      test_hazard(5'd9, 1'b1);
      test_hazard(5'd10, 1'b0);
      test_order();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
